// File: rtl/ones_count_frame_acc_pkg.sv
// Shared types and width helpers for the frame accumulator.
// Latency and backpressure: none; package only.
package ones_count_frame_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic int count_w(input int log_bit_width);
    return log_bit_width + 1;
  endfunction

  // Wide enough for a full frame of all-ones words without wrapping.
  function automatic int sum_w(input int log_bit_width, input int log_frame_len);
    return log_bit_width + log_frame_len + 1;
  endfunction

endpackage

// File: rtl/frame_acc_datapath.sv
// Accumulator, running max and sample counter for one frame.
// Latency: next-state values combinational, state 1 cycle; backpressure: none, driven by controls.
module frame_acc_datapath
  import ones_count_frame_acc_pkg::*;
#(
  parameter int log_bit_width = 5,
  parameter int log_frame_len = 4,
  localparam int CW = count_w(log_bit_width),
  localparam int SW = sum_w(log_bit_width, log_frame_len)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          acc_en,
  input  logic [CW-1:0] count_in,
  output logic [SW-1:0] sum_nxt,
  output logic [CW-1:0] max_nxt,
  output logic          last
);

  logic [SW-1:0]            acc;
  logic [CW-1:0]            max_q;
  logic [log_frame_len-1:0] cnt;

  assign sum_nxt = acc + SW'(count_in);
  assign max_nxt = (count_in > max_q) ? count_in : max_q;
  assign last    = acc_en && (cnt == {log_frame_len{1'b1}});

  // load opens a new frame with the current sample as its first entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      max_q <= '0;
      cnt   <= '0;
    end else if (clr) begin
      acc   <= '0;
      max_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= SW'(count_in);
      max_q <= count_in;
      cnt   <= log_frame_len'(1);
    end else if (acc_en) begin
      acc   <= sum_nxt;
      max_q <= max_nxt;
      cnt   <= cnt + log_frame_len'(1);
    end
  end

endmodule

// File: rtl/reg_gen.sv
// Generic enabled register with async active-high clear.
// Latency: 1 cycle; backpressure: none, holds value while en is low.
module reg_gen #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ones_count_frame_acc.sv
// Per-frame popcount totals, max and threshold flag; result 1 cycle after the last sample.
// Backpressure: result held until frame_ready; samples arriving meanwhile are dropped and flagged.
module ones_count_frame_acc
  import ones_count_frame_acc_pkg::*;
#(
  parameter int log_bit_width = 5,
  parameter int log_frame_len = 4,
  localparam int CNT_W = count_w(log_bit_width),
  localparam int SUM_W = sum_w(log_bit_width, log_frame_len)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic             count_valid,
  input  logic [CNT_W-1:0] count_in,
  input  logic [SUM_W-1:0] threshold,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [SUM_W-1:0] frame_sum,
  output logic [CNT_W-1:0] frame_max,
  output logic             above_thr,
  output logic             busy,
  output logic             drop
);

  state_t             state;
  logic               hs, done, last;
  logic               dp_clr, dp_load, dp_acc_en;
  logic [SUM_W-1:0]   sum_nxt;
  logic [CNT_W-1:0]   max_nxt;

  assign hs   = frame_valid && frame_ready;
  assign done = (state == ST_ACC) && !abort && last;

  always_comb begin
    dp_clr    = 1'b0;
    dp_load   = 1'b0;
    dp_acc_en = 1'b0;
    if (abort) begin
      dp_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: dp_clr    = start;
        ST_ACC:  dp_acc_en = count_valid;
        ST_HOLD: begin
          if (hs) begin
            if (cont && count_valid) dp_load = 1'b1;
            else                     dp_clr  = 1'b1;
          end
        end
        default: dp_clr = 1'b1;
      endcase
    end
  end

  frame_acc_datapath #(
    .log_bit_width(log_bit_width),
    .log_frame_len(log_frame_len)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .clr     (dp_clr),
    .load    (dp_load),
    .acc_en  (dp_acc_en),
    .count_in(count_in),
    .sum_nxt (sum_nxt),
    .max_nxt (max_nxt),
    .last    (last)
  );

  reg_gen #(.W(SUM_W)) u_sum_reg (
    .clk(clk), .rst(rst), .en(done), .d(sum_nxt), .q(frame_sum)
  );

  reg_gen #(.W(CNT_W)) u_max_reg (
    .clk(clk), .rst(rst), .en(done), .d(max_nxt), .q(frame_max)
  );

  reg_gen #(.W(1)) u_thr_reg (
    .clk(clk), .rst(rst), .en(done), .d(sum_nxt >= threshold), .q(above_thr)
  );

  // abort overrides every state, including a same-cycle start or frame completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      drop        <= 1'b0;
    end else if (abort) begin
      state       <= ST_IDLE;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACC;
            busy  <= 1'b1;
            drop  <= 1'b0;
          end
        end
        ST_ACC: begin
          if (done) begin
            state       <= ST_HOLD;
            frame_valid <= 1'b1;
            busy        <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (hs) begin
            frame_valid <= 1'b0;
            if (cont) begin
              state <= ST_ACC;
              busy  <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (count_valid) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ones_count_frame_acc.md
Name: ones_count_frame_acc

Overview:
- Downstream consumer of the 32-bit ones counter. It takes the registered popcount stream and accumulates it over frames of 2**log_frame_len words.
- Per frame it reports the total ones, the maximum per-word count, and a threshold flag, delivered through a valid/ready handshake.
- Typical uses are link bit-density monitoring and scrambler sanity checks.

Parameters:
- log_bit_width, 5: input word width is 2**log_bit_width; count_in width is log_bit_width+1.
- log_frame_len, 4: frame length is 2**log_frame_len accepted samples.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a frame from IDLE and clears drop.
- abort  in  1  synchronous cancel; returns to IDLE.
- cont  in  1  continuous mode; when 1, a new frame opens automatically after each handshake.
- count_valid  in  1  count_in is valid this cycle. Aligned with the counter's count_out, which arrives 2 cycles after word_in.
- count_in  in  log_bit_width+1  per-word ones count, range 0..2**log_bit_width.
- threshold  in  SUM_W  compare level, sampled in the cycle the frame completes.
- frame_valid  out  1  frame result available.
- frame_ready  in  1  consumer accepts the result.
- frame_sum  out  SUM_W  total ones in the frame. SUM_W = log_bit_width+log_frame_len+1 (10 at defaults).
- frame_max  out  log_bit_width+1  largest count_in in the frame.
- above_thr  out  1  frame_sum >= threshold.
- busy  out  1  state is ACC.
- drop  out  1  sticky: a valid sample was lost in HOLD.

Behaviour:
- Reset (async) values: state=IDLE, acc=0, max=0, sample counter=0, frame_valid=0, frame_sum=0, frame_max=0, above_thr=0, busy=0, drop=0.
- States: IDLE, ACC, HOLD.
- IDLE:
  - count_valid is ignored silently; drop is not set.
  - start -> ACC; clears acc, max, sample counter and drop.
- ACC, on each count_valid:
  - acc += count_in, with width SUM_W. It never wraps: the maximum is 2**(log_bit_width+log_frame_len), which fits in SUM_W.
  - max = max(max, count_in).
  - The sample counter increments and wraps at 2**log_frame_len.
- Frame completion:
  - On the 2**log_frame_len-th accepted sample, at edge N: frame_sum, frame_max and above_thr are loaded with values that include that sample, and the threshold is compared in the same cycle.
  - frame_valid=1 from cycle N+1 and the state moves to HOLD. Latency from last sample to frame_valid is 1 cycle.
- HOLD:
  - frame_sum, frame_max, above_thr and frame_valid are held stable until frame_ready.
  - count_valid without a handshake sets drop; the sample is discarded.
- Handshake (frame_valid && frame_ready): frame_valid goes 0 next cycle.
  - cont=1 -> ACC. A count_valid in the same cycle is accepted as sample 0 of the new frame: acc=count_in, max=count_in, counter=1.
  - cont=0 -> IDLE. A same-cycle count_valid is ignored and drop is not set.
- start while in ACC or HOLD is ignored.
- abort:
  - Accepted in any state -> IDLE; acc, max and counter are cleared.
  - frame_valid=0 next cycle. frame_sum, frame_max and above_thr keep their last values. drop is unchanged.
  - abort and start in the same cycle: abort wins.
- rst asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package: SUM_W derivation function, state encoding constants (IDLE/ACC/HOLD), count width function (log_bit_width+1).
- One natural sub-module, frame_acc_datapath: holds the accumulator, max tracker and sample counter, with load/clear/enable controls. The FSM and handshake stay in the top module.
- Output registers reuse the existing reg_gen register.

Test Plan:
- log_frame_len=2, threshold=40, start, counts 32,0,5,7 on consecutive valids -> one cycle after the 4th sample: frame_valid=1, frame_sum=44, frame_max=32, above_thr=1.
- Defaults, 16 valid samples of count 32 -> frame_sum=512 (no wrap), frame_max=32; with threshold=513, above_thr=0.
- log_frame_len=2, frame completes, frame_ready=0 for 5 cycles with 2 valids (count 9) -> drop=1, frame_sum unchanged at 44; a later start clears drop to 0.
- cont=1, handshake cycle carries count_valid with count_in=3, followed by 1,1,1 -> next frame_sum=6, frame_max=3.
- abort after 2 samples (10,20), then start and 4 samples of 1 -> frame_sum=4; busy=0 for exactly the cycles spent in IDLE.
- rst pulsed mid-HOLD between clock edges -> frame_valid, frame_sum, busy and drop read 0 before the next rising edge.
